// File: rtl/cpu_pkg.sv
// Shared ELEC374 CPU definitions: instruction field positions, opcodes, ALU codes,
// the control-unit state encoding and the decoded instruction classes.
package cpu_pkg;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 27;
   localparam int RA_MSB  = 26;
   localparam int RA_LSB  = 23;
   localparam int RB_MSB  = 22;
   localparam int RB_LSB  = 19;
   localparam int RC_MSB  = 18;
   localparam int RC_LSB  = 15;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_SHRA = 5'b01000;
   localparam logic [4:0] OP_SHL  = 5'b01001;
   localparam logic [4:0] OP_ROR  = 5'b01010;
   localparam logic [4:0] OP_ROL  = 5'b01011;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   // ALU codes deliberately coincide with the register-form opcodes.
   localparam logic [4:0] ALU_NONE = 5'b00000;
   localparam logic [4:0] ALU_ADD  = OP_ADD;
   localparam logic [4:0] ALU_AND  = OP_AND;
   localparam logic [4:0] ALU_OR   = OP_OR;

   typedef enum logic [3:0] {
      RST, T0, T1, T2, T3, T4, T5, T6, T7, PAUSE, HALT
   } state_t;

   typedef enum logic [2:0] {
      CLS_RTYPE, CLS_IMM, CLS_UNARY, CLS_MULDIV, CLS_LD, CLS_ST, CLS_HALT, CLS_NOP
   } instr_class_t;

endpackage

// File: rtl/control_decoder.sv
// Combinational opcode decode: instruction class plus the ALU code used in T4.
module control_decoder
   import cpu_pkg::*;
(
   input  logic [4:0]   opcode,
   output instr_class_t iclass,
   output logic [4:0]   alu_op
);

   always_comb begin
      iclass = CLS_NOP;
      alu_op = ALU_NONE;
      case (opcode)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL: begin
            iclass = CLS_RTYPE;
            alu_op = opcode;
         end
         OP_ADDI: begin
            iclass = CLS_IMM;
            alu_op = ALU_ADD;
         end
         OP_ANDI: begin
            iclass = CLS_IMM;
            alu_op = ALU_AND;
         end
         OP_ORI: begin
            iclass = CLS_IMM;
            alu_op = ALU_OR;
         end
         OP_NEG, OP_NOT: begin
            iclass = CLS_UNARY;
            alu_op = opcode;
         end
         OP_MUL, OP_DIV: begin
            iclass = CLS_MULDIV;
            alu_op = opcode;
         end
         // Address generation for memory ops is rb + C, so both use the adder.
         OP_LD: begin
            iclass = CLS_LD;
            alu_op = ALU_ADD;
         end
         OP_ST: begin
            iclass = CLS_ST;
            alu_op = ALU_ADD;
         end
         OP_HALT: iclass = CLS_HALT;
         default: iclass = CLS_NOP;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// T-state sequencer for the ELEC374 datapath: fetch, decode of the fed-back IR,
// and Moore decode of every datapath strobe from the registered state.
module control_unit
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] ir,
   input  logic        mem_ready,
   input  logic        stop,
   output logic        PCout,
   output logic        PCin,
   output logic        IncPC,
   output logic        MARin,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        Yin,
   output logic        ZLOin,
   output logic        ZHIin,
   output logic        Zlowout,
   output logic        ZHighout,
   output logic        HIin,
   output logic        LOin,
   output logic        Cout,
   output logic        BAout,
   output logic        Read,
   output logic        Write,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic [4:0]  operation,
   output logic        run
);

   state_t       state;
   state_t       next_state;
   state_t       done_state;
   instr_class_t iclass;
   logic [4:0]   alu_op;

   // Register fields are consumed by the datapath's select/encode logic, not here.
   logic unused_ir_fields;
   assign unused_ir_fields = ^ir[RA_MSB:0];

   control_decoder u_decoder (
      .opcode (ir[OPC_MSB:OPC_LSB]),
      .iclass (iclass),
      .alu_op (alu_op)
   );

   always_ff @(posedge clk) begin
      if (!clr) state <= RST;
      else      state <= next_state;
   end

   assign done_state = stop ? PAUSE : T0;

   always_comb begin
      next_state = state;
      case (state)
         RST: next_state = T0;
         T0:  next_state = T1;
         T1:  next_state = mem_ready ? T2 : T1;
         T2:  next_state = T3;
         T3: begin
            case (iclass)
               CLS_HALT: next_state = HALT;
               CLS_NOP:  next_state = done_state;
               default:  next_state = T4;
            endcase
         end
         T4: next_state = T5;
         T5: begin
            case (iclass)
               CLS_MULDIV, CLS_LD, CLS_ST: next_state = T6;
               default:                    next_state = done_state;
            endcase
         end
         T6: begin
            case (iclass)
               CLS_LD:  next_state = mem_ready ? T7 : T6;
               CLS_ST:  next_state = T7;
               default: next_state = done_state;
            endcase
         end
         T7: begin
            if (iclass == CLS_ST && !mem_ready) next_state = T7;
            else                                next_state = done_state;
         end
         PAUSE:   next_state = stop ? PAUSE : T0;
         HALT:    next_state = HALT;
         default: next_state = RST;
      endcase
   end

   always_comb begin
      {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, ZLOin, ZHIin} = '0;
      {Zlowout, ZHighout, HIin, LOin, Cout, BAout, Read, Write} = '0;
      {Gra, Grb, Grc, Rin, Rout} = '0;
      operation = ALU_NONE;
      run = 1'b0;
      case (state)
         T0: begin
            run = 1'b1;
            {PCout, MARin, IncPC, ZLOin} = '1;
         end
         T1: begin
            run = 1'b1;
            {Zlowout, PCin, Read, MDRin} = '1;
         end
         T2: begin
            run = 1'b1;
            {MDRout, IRin} = '1;
         end
         T3: begin
            run = 1'b1;
            case (iclass)
               CLS_RTYPE, CLS_IMM, CLS_UNARY: {Grb, Rout, Yin} = '1;
               CLS_MULDIV:                    {Gra, Rout, Yin} = '1;
               CLS_LD, CLS_ST:                {Grb, BAout, Yin} = '1;
               default: ;
            endcase
         end
         T4: begin
            run = 1'b1;
            case (iclass)
               CLS_RTYPE:              {Grc, Rout, ZLOin} = '1;
               CLS_UNARY:              {Grb, Rout, ZLOin} = '1;
               CLS_MULDIV:             {Grb, Rout, ZLOin, ZHIin} = '1;
               CLS_IMM, CLS_LD, CLS_ST: {Cout, ZLOin} = '1;
               default: ;
            endcase
            if (iclass != CLS_NOP && iclass != CLS_HALT) operation = alu_op;
         end
         T5: begin
            run = 1'b1;
            case (iclass)
               CLS_RTYPE, CLS_IMM, CLS_UNARY: {Zlowout, Gra, Rin} = '1;
               CLS_MULDIV:                    {Zlowout, LOin} = '1;
               CLS_LD, CLS_ST:                {Zlowout, MARin} = '1;
               default: ;
            endcase
         end
         T6: begin
            run = 1'b1;
            case (iclass)
               CLS_MULDIV: {ZHighout, HIin} = '1;
               CLS_LD:     {Read, MDRin} = '1;
               CLS_ST:     {Gra, Rout, MDRin} = '1;
               default: ;
            endcase
         end
         T7: begin
            run = 1'b1;
            case (iclass)
               CLS_LD:  {MDRout, Gra, Rin} = '1;
               CLS_ST:  Write = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a per-cycle expected-strobe script is built
// from the instruction rules and replayed against the DUT with randomized side inputs.
module tb_control_unit;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic [31:0] ir = '0;
   logic        mem_ready = 1'b1;
   logic        stop = 1'b0;
   logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, ZLOin, ZHIin;
   logic Zlowout, ZHighout, HIin, LOin, Cout, BAout, Read, Write;
   logic Gra, Grb, Grc, Rin, Rout, run;
   logic [4:0] operation;

   control_unit dut (
      .clk(clk), .clr(clr), .ir(ir), .mem_ready(mem_ready), .stop(stop),
      .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
      .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .ZLOin(ZLOin), .ZHIin(ZHIin),
      .Zlowout(Zlowout), .ZHighout(ZHighout), .HIin(HIin), .LOin(LOin),
      .Cout(Cout), .BAout(BAout), .Read(Read), .Write(Write),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
      .operation(operation), .run(run)
   );

   always #5 clk = ~clk;

   localparam logic [22:0] M_PCOUT = 23'd1 << 0,  M_PCIN = 23'd1 << 1,  M_INCPC = 23'd1 << 2;
   localparam logic [22:0] M_MARIN = 23'd1 << 3,  M_MDRIN = 23'd1 << 4, M_MDROUT = 23'd1 << 5;
   localparam logic [22:0] M_IRIN = 23'd1 << 6,   M_YIN = 23'd1 << 7,   M_ZLOIN = 23'd1 << 8;
   localparam logic [22:0] M_ZHIIN = 23'd1 << 9,  M_ZLOWOUT = 23'd1 << 10, M_ZHIGHOUT = 23'd1 << 11;
   localparam logic [22:0] M_HIIN = 23'd1 << 12,  M_LOIN = 23'd1 << 13, M_COUT = 23'd1 << 14;
   localparam logic [22:0] M_BAOUT = 23'd1 << 15, M_READ = 23'd1 << 16, M_WRITE = 23'd1 << 17;
   localparam logic [22:0] M_GRA = 23'd1 << 18,   M_GRB = 23'd1 << 19,  M_GRC = 23'd1 << 20;
   localparam logic [22:0] M_RIN = 23'd1 << 21,   M_ROUT = 23'd1 << 22;

   logic [28:0] actual;
   assign actual = {run, operation, Rout, Rin, Grc, Grb, Gra, Write, Read, BAout, Cout,
                    LOin, HIin, ZHighout, Zlowout, ZHIin, ZLOin, Yin, IRin, MDRout,
                    MDRin, MARin, IncPC, PCin, PCout};

   // One entry per clock: what the outputs must show, and what to drive before the next edge.
   typedef struct {
      logic [28:0] exp;
      logic        mr;
      logic        stp;
      logic        cl;
      logic [31:0] irv;
   } step_t;

   step_t q[$];
   int errors = 0;
   int checks = 0;

   task automatic add_step(input logic [22:0] m, input logic [4:0] op, input int waits,
                           input bit wstate, input logic [31:0] irv);
      for (int i = 0; i <= waits; i++) begin
         step_t s;
         s.exp = {1'b1, op, m};
         s.mr  = wstate ? ((i < waits) ? 1'b0 : 1'b1) : 1'($urandom);
         s.stp = 1'($urandom);
         s.cl  = 1'b1;
         s.irv = irv;
         q.push_back(s);
      end
   endtask

   task automatic add_idle(input logic cl, input logic stp, input logic [31:0] irv);
      step_t s;
      s.exp = '0;
      s.mr  = 1'($urandom);
      s.stp = stp;
      s.cl  = cl;
      s.irv = irv;
      q.push_back(s);
   endtask

   // Script one instruction from fetch to its end (plus PAUSE or HALT tail if requested).
   task automatic push_instr(input logic [31:0] irv, input int w1, input int wm,
                             input bit stop_end, input int halt_len);
      logic [4:0] opc;
      logic [4:0] aop;
      step_t s;
      int npause;
      opc = irv[31:27];
      add_step(M_PCOUT | M_MARIN | M_INCPC | M_ZLOIN, 5'd0, 0, 1'b0, $urandom);
      add_step(M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 5'd0, w1, 1'b1, $urandom);
      add_step(M_MDROUT | M_IRIN, 5'd0, 0, 1'b0, irv);
      if (opc inside {[5'd3:5'd14], 5'd17, 5'd18}) begin
         aop = (opc == 5'd12) ? 5'd3 : (opc == 5'd13) ? 5'd5 : (opc == 5'd14) ? 5'd6 : opc;
         add_step(M_GRB | M_ROUT | M_YIN, 5'd0, 0, 1'b0, irv);
         if (opc inside {[5'd12:5'd14]})   add_step(M_COUT | M_ZLOIN, aop, 0, 1'b0, irv);
         else if (opc inside {5'd17, 5'd18}) add_step(M_GRB | M_ROUT | M_ZLOIN, aop, 0, 1'b0, irv);
         else                              add_step(M_GRC | M_ROUT | M_ZLOIN, aop, 0, 1'b0, irv);
         add_step(M_ZLOWOUT | M_GRA | M_RIN, 5'd0, 0, 1'b0, irv);
      end else if (opc inside {5'd15, 5'd16}) begin
         add_step(M_GRA | M_ROUT | M_YIN, 5'd0, 0, 1'b0, irv);
         add_step(M_GRB | M_ROUT | M_ZLOIN | M_ZHIIN, opc, 0, 1'b0, irv);
         add_step(M_ZLOWOUT | M_LOIN, 5'd0, 0, 1'b0, irv);
         add_step(M_ZHIGHOUT | M_HIIN, 5'd0, 0, 1'b0, irv);
      end else if (opc inside {5'd0, 5'd2}) begin
         add_step(M_GRB | M_BAOUT | M_YIN, 5'd0, 0, 1'b0, irv);
         add_step(M_COUT | M_ZLOIN, 5'd3, 0, 1'b0, irv);
         add_step(M_ZLOWOUT | M_MARIN, 5'd0, 0, 1'b0, irv);
         if (opc == 5'd0) begin
            add_step(M_READ | M_MDRIN, 5'd0, wm, 1'b1, irv);
            add_step(M_MDROUT | M_GRA | M_RIN, 5'd0, 0, 1'b0, irv);
         end else begin
            add_step(M_GRA | M_ROUT | M_MDRIN, 5'd0, 0, 1'b0, irv);
            add_step(M_WRITE, 5'd0, wm, 1'b1, irv);
         end
      end else if (opc == 5'd27) begin
         add_step(23'd0, 5'd0, 0, 1'b0, irv);
         for (int i = 0; i < halt_len; i++) add_idle(1'b1, 1'($urandom), irv);
         s = q.pop_back();
         s.cl = 1'b0;
         q.push_back(s);
         add_idle(1'b1, 1'($urandom), irv);
         return;
      end else begin
         add_step(23'd0, 5'd0, 0, 1'b0, irv);
      end
      s = q.pop_back();
      s.stp = stop_end;
      q.push_back(s);
      if (stop_end) begin
         npause = 1 + $urandom_range(0, 3);
         for (int i = 0; i < npause; i++) add_idle(1'b1, (i < npause - 1) ? 1'b1 : 1'b0, irv);
      end
   endtask

   // Replay the script: check on the falling edge, then drive inputs for the next rising edge.
   task automatic exec(input string name);
      int idx = 0;
      while (q.size() > 0) begin
         step_t s;
         @(negedge clk);
         s = q.pop_front();
         checks++;
         if (actual !== s.exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %h want %h", name, idx, actual, s.exp);
         end
         mem_ready = s.mr;
         stop      = s.stp;
         clr       = s.cl;
         ir        = s.irv;
         idx++;
      end
   endtask

   function automatic logic [31:0] mk_ir(input logic [4:0] opc);
      logic [26:0] fields;
      fields = 27'($urandom);
      return {opc, fields};
   endfunction

   task automatic test_reset();
      clr = 1'b0;
      ir = 32'h28918000;
      repeat (2) @(posedge clk);
      add_idle(1'b0, 1'b1, 32'h28918000);
      add_idle(1'b1, 1'b0, 32'h28918000);
      exec("reset");
   endtask

   task automatic test_rtype_and();
      push_instr(32'h28918000, 0, 0, 1'b0, 0);
      push_instr(mk_ir(5'd3), 1, 0, 1'b0, 0);
      exec("rtype");
   endtask

   task automatic test_imm_unary();
      push_instr(mk_ir(5'd12), 0, 0, 1'b0, 0);
      push_instr(mk_ir(5'd14), 0, 0, 1'b0, 0);
      push_instr(mk_ir(5'd18), 0, 0, 1'b0, 0);
      exec("imm_unary");
   endtask

   task automatic test_mul();
      push_instr(mk_ir(5'd15), 0, 0, 1'b0, 0);
      push_instr(mk_ir(5'd16), 0, 0, 1'b0, 0);
      exec("muldiv");
   endtask

   task automatic test_ld_wait();
      push_instr(mk_ir(5'd0), 0, 3, 1'b0, 0);
      exec("ld_wait");
   endtask

   task automatic test_st();
      push_instr(mk_ir(5'd2), 0, 0, 1'b0, 0);
      push_instr(mk_ir(5'd2), 0, 2, 1'b0, 0);
      exec("st");
   endtask

   task automatic test_nop_and_unknown();
      push_instr(mk_ir(5'd26), 0, 0, 1'b0, 0);
      push_instr(mk_ir(5'd1), 0, 0, 1'b0, 0);
      exec("nop");
   endtask

   task automatic test_clr_mid();
      step_t s;
      int base;
      base = q.size();
      push_instr(mk_ir(5'd3), 0, 0, 1'b0, 0);
      while (q.size() > base + 5) void'(q.pop_back());
      s = q.pop_back();
      s.cl  = 1'b0;
      s.stp = 1'b1;
      s.mr  = 1'b0;
      q.push_back(s);
      add_idle(1'b1, 1'b0, s.irv);
      exec("clr_mid");
   endtask

   task automatic test_stop_pause();
      push_instr(mk_ir(5'd4), 0, 0, 1'b1, 0);
      push_instr(mk_ir(5'd0), 0, 0, 1'b1, 0);
      exec("stop_pause");
   endtask

   task automatic test_halt();
      push_instr(mk_ir(5'd27), 0, 0, 1'b0, 20);
      push_instr(mk_ir(5'd5), 0, 0, 1'b0, 0);
      exec("halt");
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         push_instr(mk_ir(5'($urandom)), $urandom_range(0, 2), $urandom_range(0, 3),
                    ($urandom_range(0, 3) == 0), 3);
         exec("random");
      end
   endtask

   initial begin
      test_reset();
      test_rtype_and();
      test_imm_unary();
      test_mul();
      test_ld_wait();
      test_st();
      test_nop_and_unknown();
      test_clr_mid();
      test_stop_pause();
      test_halt();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
